// File: rtl/mac_array_engine.sv
// ---------------------------------------------------------------------------
// mac_array_engine
//   CH parallel unsigned multiply-accumulate lanes over a programmable-length
//   frame of operand pairs. Each lane result is right-shifted by OUT_SHIFT,
//   saturated to DATA_W bits, then the CH results are serialised (lane 0
//   first) onto one valid/ready stream through an output function f(x).
//
//   Optional build macro: MAC_ARRAY_AF_EN
//     defined   : f(x) is the quadratic activation (x read as signed DATA_W)
//     undefined : f(x) is x zero-extended to 2*DATA_W
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start, len_cfg    frame start (IDLE only) and operand pairs per frame
//   in_valid/in_ready operand bundle handshake; in_a/in_b lane-packed
//   out_valid/out_ready, out_data, out_lane   serial result stream
//   busy              high outside IDLE
//   ovf               per-lane sticky accumulator saturation, cleared at start
//   done              one-cycle pulse after the last word is accepted
// ---------------------------------------------------------------------------
module mac_array_engine #(
    parameter int DATA_W    = 8,
    parameter int CH        = 2,
    parameter int ACC_W     = 20,
    parameter int OUT_SHIFT = 9,
    parameter int LEN_W     = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [LEN_W-1:0]                     len_cfg,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [CH*DATA_W-1:0]                 in_a,
    input  logic [CH*DATA_W-1:0]                 in_b,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [2*DATA_W-1:0]                  out_data,
    output logic [((CH > 1) ? $clog2(CH) : 1)-1:0] out_lane,
    output logic                                 busy,
    output logic [CH-1:0]                        ovf,
    output logic                                 done
);

    localparam int LANE_W = (CH > 1) ? $clog2(CH) : 1;
    localparam int PROD_W = 2 * DATA_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_DRAIN,
        S_SERIAL
    } state_t;

    state_t              r_state;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_cnt;
    logic [1:0]          r_drain;

    logic [DATA_W-1:0]   r_a   [CH];
    logic [DATA_W-1:0]   r_b   [CH];
    logic [PROD_W-1:0]   r_p   [CH];
    logic [ACC_W-1:0]    r_acc [CH];
    logic [DATA_W-1:0]   r_res [CH];
    logic                r_v1;
    logic                r_v2;

    logic [ACC_W:0]      w_sum   [CH];
    logic [ACC_W-1:0]    w_shift [CH];
    logic [DATA_W-1:0]   w_res   [CH];
    logic                w_accept;
    logic                w_frame_start;
    logic [LANE_W-1:0]   w_idx_nxt;

    // Output function applied to each saturated lane result.
    function automatic logic [PROD_W-1:0] f_out(input logic [DATA_W-1:0] x);
`ifdef MAC_ARRAY_AF_EN
        logic [DATA_W-1:0]        y;
        logic [DATA_W-1:0]        z;
        logic signed [DATA_W-1:0] s;
        logic signed [PROD_W-1:0] sq;
        y  = x[DATA_W-1] ? (~x + DATA_W'(1)) : x;
        z  = y >> 2;
        s  = $signed(z - DATA_W'(16));
        sq = PROD_W'(s) * PROD_W'(s);
        sq = sq >>> 1;
        return x[DATA_W-1] ? sq : (PROD_W'(256) - sq);
`else
        return {{DATA_W{1'b0}}, x};
`endif
    endfunction

    assign w_accept      = in_valid & in_ready;
    assign w_frame_start = (r_state == S_IDLE) & start & (len_cfg != '0);
    assign w_idx_nxt     = out_lane + LANE_W'(1);

    always_comb begin
        for (int unsigned c = 0; c < CH; c++) begin
            w_sum[c]   = {1'b0, r_acc[c]} + (ACC_W + 1)'(r_p[c]);
            w_shift[c] = r_acc[c] >> OUT_SHIFT;
            w_res[c]   = (|w_shift[c][ACC_W-1:DATA_W]) ? '1 : w_shift[c][DATA_W-1:0];
        end
    end

    // Three-stage lane datapath: operand register, product, accumulate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            ovf  <= '0;
            for (int unsigned c = 0; c < CH; c++) begin
                r_a[c]   <= '0;
                r_b[c]   <= '0;
                r_p[c]   <= '0;
                r_acc[c] <= '0;
            end
        end else begin
            r_v1 <= w_accept;
            r_v2 <= r_v1;
            for (int unsigned c = 0; c < CH; c++) begin
                if (w_accept) begin
                    r_a[c] <= in_a[c*DATA_W +: DATA_W];
                    r_b[c] <= in_b[c*DATA_W +: DATA_W];
                end
                if (r_v1) begin
                    r_p[c] <= PROD_W'(r_a[c]) * PROD_W'(r_b[c]);
                end
            end
            if (w_frame_start) begin
                ovf <= '0;
                for (int unsigned c = 0; c < CH; c++) begin
                    r_acc[c] <= '0;
                end
            end else if (r_v2) begin
                for (int unsigned c = 0; c < CH; c++) begin
                    if (w_sum[c][ACC_W]) begin
                        r_acc[c] <= '1;
                        ovf[c]   <= 1'b1;
                    end else begin
                        r_acc[c] <= w_sum[c][ACC_W-1:0];
                    end
                end
            end
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_len     <= '0;
            r_cnt     <= '0;
            r_drain   <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_lane  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            for (int unsigned c = 0; c < CH; c++) begin
                r_res[c] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_frame_start) begin
                        r_len    <= len_cfg;
                        r_cnt    <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        r_state  <= S_ACC;
                    end
                end
                S_ACC: begin
                    if (w_accept) begin
                        if (r_cnt == r_len - LEN_W'(1)) begin
                            in_ready <= 1'b0;
                            r_drain  <= '0;
                            r_state  <= S_DRAIN;
                        end else begin
                            r_cnt <= r_cnt + LEN_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    // Waits out the product and accumulate stages of the last
                    // sample, so the first word appears 4 cycles after the last
                    // accept edge with its activation already applied.
                    if (r_drain == 2'd3) begin
                        for (int unsigned c = 0; c < CH; c++) begin
                            r_res[c] <= w_res[c];
                        end
                        out_lane  <= '0;
                        out_data  <= f_out(w_res[0]);
                        out_valid <= 1'b1;
                        r_state   <= S_SERIAL;
                    end else begin
                        r_drain <= r_drain + 2'd1;
                    end
                end
                S_SERIAL: begin
                    if (out_valid && out_ready) begin
                        if (out_lane == LANE_W'(CH - 1)) begin
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            r_state   <= S_IDLE;
                        end else begin
                            out_lane <= w_idx_nxt;
                            out_data <= f_out(r_res[w_idx_nxt]);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_array_engine.sv
module tb_mac_array_engine;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  len_cfg;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [0:0]  out_lane;
    logic        busy;
    logic [1:0]  ovf;
    logic        done;

    mac_array_engine #(
        .DATA_W    (8),
        .CH        (2),
        .ACC_W     (20),
        .OUT_SHIFT (9),
        .LEN_W     (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len_cfg   (len_cfg),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_lane  (out_lane),
        .busy      (busy),
        .ovf       (ovf),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef MAC_ARRAY_AF_EN
    localparam bit AF = 1'b1;
`else
    localparam bit AF = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int len;
        int a0, b0, a1, b1;
        int e0, e1;       // expected words, plain build
        int f0, f1;       // expected words, activation build
        int eovf;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a frame and feed len samples; optional idle gaps drive junk
    // operands with in_valid low. Returns #1 after the last accept edge.
    task automatic do_frame(input int len, input int a0, input int b0,
                            input int a1, input int b1, input bit gaps);
        int  n;
        int  g;
        bit  ph;
        bit  acc;
        start   = 1'b1;
        len_cfg = 8'(len);
        tick();
        start   = 1'b0;
        len_cfg = '0;
        n  = 0;
        g  = 0;
        ph = 1'b0;
        while (n < len && g < 500) begin
            if (gaps && ph) begin
                in_valid = 1'b0;
                in_a     = '1;
                in_b     = '1;
            end else begin
                in_valid = 1'b1;
                in_a     = {a1[7:0], a0[7:0]};
                in_b     = {b1[7:0], b0[7:0]};
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) n++;
            g++;
            ph = !ph;
        end
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        chk("accepts", n, len);
    endtask

    // Drain both output words with out_ready high; lat is the number of
    // cycles waited for the first word.
    task automatic collect(output int lane0, output int data0,
                           output int lane1, output int data1, output int lat);
        int k;
        out_ready = 1'b1;
        k = 0;
        while (!out_valid && k < 50) begin
            tick();
            k++;
        end
        lat = k;
        chk("out_valid_w0", int'(out_valid), 1);
        lane0 = int'(out_lane);
        data0 = int'(out_data);
        tick();
        chk("out_valid_w1", int'(out_valid), 1);
        lane1 = int'(out_lane);
        data1 = int'(out_data);
        tick();
        chk("done_pulse", int'(done), 1);
        chk("out_valid_end", int'(out_valid), 0);
        tick();
        chk("done_clear", int'(done), 0);
        chk("busy_idle", int'(busy), 0);
    endtask

    task automatic chk_words(input string tag, input int l0, input int d0,
                             input int l1, input int d1, input int x0, input int x1);
        chk({tag, "_lane0"}, l0, 0);
        chk({tag, "_data0"}, d0, x0);
        chk({tag, "_lane1"}, l1, 1);
        chk({tag, "_data1"}, d1, x1);
    endtask

    initial begin
        int l0, d0, l1, d1, lat, k;

        vecs[0] = '{1,  200, 200, 10,  10,  78,  0,   252, 128, 0};
        vecs[1] = '{4,  100, 100, 3,   7,   78,  0,   252, 128, 0};
        vecs[2] = '{30, 255, 255, 255, 255, 255, 255, 128, 128, 3};
        vecs[3] = '{1,  0,   0,   255, 255, 0,   127, 128, 144, 0};
        vecs[4] = '{16, 255, 255, 16,  16,  255, 8,   128, 158, 0};
        vecs[5] = '{17, 255, 255, 1,   1,   255, 0,   128, 128, 1};
        vecs[6] = '{4,  160, 160, 0,   0,   200, 0,   2,   128, 0};

        rst       = 1'b1;
        start     = 1'b0;
        len_cfg   = '0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        repeat (3) tick();
        chk("reset_outputs", int'({busy, in_ready, out_valid, done, ovf, out_lane, out_data}), 0);
        rst = 1'b0;
        tick();

        // Table-driven frames, continuous input, no output backpressure.
        for (int i = 0; i < 7; i++) begin
            do_frame(vecs[i].len, vecs[i].a0, vecs[i].b0, vecs[i].a1, vecs[i].b1, 1'b0);
            chk($sformatf("v%0d_in_ready_drop", i), int'(in_ready), 0);
            chk($sformatf("v%0d_busy", i), int'(busy), 1);
            collect(l0, d0, l1, d1, lat);
            chk($sformatf("v%0d_latency", i), lat, 4);
            chk_words($sformatf("v%0d", i), l0, d0, l1, d1,
                      AF ? vecs[i].f0 : vecs[i].e0, AF ? vecs[i].f1 : vecs[i].e1);
            chk($sformatf("v%0d_ovf", i), int'(ovf), vecs[i].eovf);
        end

        // Gapped input: junk operands while in_valid is low must not count.
        do_frame(4, 100, 100, 3, 7, 1'b1);
        collect(l0, d0, l1, d1, lat);
        chk("gap_latency", lat, 4);
        chk_words("gap", l0, d0, l1, d1, AF ? 252 : 78, AF ? 128 : 0);
        chk("gap_ovf", int'(ovf), 0);

        // Output backpressure on lane 0 for 5 cycles.
        out_ready = 1'b0;
        do_frame(1, 200, 200, 10, 10, 1'b0);
        k = 0;
        while (!out_valid && k < 50) begin
            tick();
            k++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", int'(out_valid), 1);
            chk("bp_lane", int'(out_lane), 0);
            chk("bp_data", int'(out_data), AF ? 252 : 78);
            chk("bp_no_done", int'(done), 0);
            tick();
        end
        collect(l0, d0, l1, d1, lat);
        chk_words("bp", l0, d0, l1, d1, AF ? 252 : 78, AF ? 128 : 0);

        // start pulses during ACC and SERIAL must be ignored.
        start   = 1'b1;
        len_cfg = 8'd2;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_a     = {8'd10, 8'd200};
        in_b     = {8'd10, 8'd200};
        tick();
        in_valid = 1'b0;
        start    = 1'b1;
        len_cfg  = 8'd1;
        tick();
        start    = 1'b0;
        len_cfg  = '0;
        chk("ign_acc_busy", int'(busy), 1);
        chk("ign_acc_ready", int'(in_ready), 1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("ign_acc_drop", int'(in_ready), 0);
        out_ready = 1'b0;
        k = 0;
        while (!out_valid && k < 50) begin
            tick();
            k++;
        end
        start   = 1'b1;
        len_cfg = 8'd3;
        tick();
        tick();
        start   = 1'b0;
        len_cfg = '0;
        chk("ign_ser_valid", int'(out_valid), 1);
        chk("ign_ser_lane", int'(out_lane), 0);
        chk("ign_ser_busy", int'(busy), 1);
        collect(l0, d0, l1, d1, lat);
        chk_words("ign", l0, d0, l1, d1, AF ? 40 : 156, AF ? 128 : 0);

        // start with len_cfg = 0 stays in IDLE.
        start   = 1'b1;
        len_cfg = '0;
        repeat (3) tick();
        start = 1'b0;
        chk("len0_busy", int'(busy), 0);
        chk("len0_ready", int'(in_ready), 0);

        // Reset in the middle of an accumulation, then a clean frame.
        start   = 1'b1;
        len_cfg = 8'd4;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_a     = '1;
        in_b     = '1;
        tick();
        tick();
        rst = 1'b1;
        #2;
        chk("midrst_outputs", int'({busy, in_ready, out_valid, done, ovf, out_lane, out_data}), 0);
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        tick();
        rst = 1'b0;
        tick();
        chk("midrst_idle", int'(busy), 0);
        do_frame(1, 200, 200, 10, 10, 1'b0);
        collect(l0, d0, l1, d1, lat);
        chk("midrst_latency", lat, 4);
        chk_words("midrst", l0, d0, l1, d1, AF ? 252 : 78, AF ? 128 : 0);
        chk("midrst_ovf", int'(ovf), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
